// File: rtl/pong_pkg.sv
// Shared definitions for the key debouncer: per-channel FSM state encoding,
// default timing constants and a small constant-evaluation helper.
// Optional feature macro: KEY_REPEAT_EN (auto-repeat of press pulses).
package pong_pkg;

  // Per-channel debounce FSM states
  typedef enum logic [1:0] {
    KEY_IDLE         = 2'd0,
    KEY_PRESS_WAIT   = 2'd1,
    KEY_PRESSED      = 2'd2,
    KEY_RELEASE_WAIT = 2'd3
  } key_state_t;

  // 10 ms at 50 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES     = 500_000;
  // 500 ms before the first repeat, then one repeat every 100 ms
  localparam int DEFAULT_REPEAT_DELAY_CYCLES = 25_000_000;
  localparam int DEFAULT_REPEAT_RATE_CYCLES  = 5_000_000;

  // Larger of two integers, used when sizing counters from parameters
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debouncer_if.sv
// Key bundle: raw key inputs plus the debounced level and event pulses.
// W is the number of key channels carried by one instance.
// Optional feature macro: KEY_REPEAT_EN (affects only the press pulse timing).
interface key_debouncer_if #(
  parameter int W = 1
) ();

  logic [W-1:0] keys;     // raw board keys
  logic [W-1:0] pressed;  // debounced level, 1 = pressed
  logic [W-1:0] press;    // one-cycle press (and repeat) pulse
  logic [W-1:0] rel;      // one-cycle release pulse

  // Key source / event consumer side
  modport master (output keys, input pressed, input press, input rel);
  // Debouncer side
  modport slave  (input keys, output pressed, output press, output rel);

endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, polarity normalisation, 4-state
// debounce FSM and registered level/pulse outputs. The output stage adds one
// cycle so that a new stable level shows up DEBOUNCE_CYCLES+3 edges after it
// is first sampled.
// Optional feature macro: KEY_REPEAT_EN (auto-repeat press pulses while held).
module key_debounce_ch
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = DEFAULT_DEBOUNCE_CYCLES,
  parameter int ACTIVE_LOW          = 1,
  parameter int REPEAT_DELAY_CYCLES = DEFAULT_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES  = DEFAULT_REPEAT_RATE_CYCLES
) (
  input  logic            clk_i,
  input  logic            rst_i,
  key_debouncer_if.slave  bus
);

  // Reject parameter sets that would break the counters at elaboration time
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY_CYCLES < 1 || REPEAT_RATE_CYCLES < 1) begin : g_bad_params
    $error("key_debounce_ch: invalid timing parameters");
  end

  localparam int                CNT_W        = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Raw level of a released key; also the XOR mask that maps raw to "1 = pressed"
  localparam logic              RAW_RELEASED = (ACTIVE_LOW != 0);

  logic [1:0]       sync_q;
  logic             sample;
  key_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             held;
  logic             pressed_q, pressed_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

`ifdef KEY_REPEAT_EN
  localparam int                REP_W          = $clog2(max_int(max_int(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES), 2));
  localparam logic [REP_W-1:0]  REP_DELAY_LAST = REP_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_RATE_LAST  = REP_W'(REPEAT_RATE_CYCLES - 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_first_q, rep_first_d;
  logic             rep_fire;
`endif

  // Synchronize the raw key; reset parks both flops at the released level
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {2{RAW_RELEASED}};
    end else begin
      sync_q <= {sync_q[0], bus.keys[0]};
    end
  end

  assign sample = sync_q[1] ^ RAW_RELEASED;

  // FSM state and debounce counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= KEY_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: a level is accepted after DEBOUNCE_CYCLES+1 agreeing samples
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      KEY_IDLE: begin
        if (sample) begin
          state_d = KEY_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      KEY_PRESS_WAIT: begin
        if (!sample) begin
          state_d = KEY_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = KEY_PRESSED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      KEY_PRESSED: begin
        if (!sample) begin
          state_d = KEY_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      KEY_RELEASE_WAIT: begin
        if (sample) begin
          state_d = KEY_PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = KEY_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = KEY_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: level follows the FSM, pulses mark edges of that level
  always_comb begin
    held      = (state_q == KEY_PRESSED) || (state_q == KEY_RELEASE_WAIT);
    pressed_d = held;
    press_d   = held && !pressed_q;
    release_d = !held && pressed_q;
`ifdef KEY_REPEAT_EN
    // Repeat timer restarts on the initial press and whenever the key is not held
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    rep_fire    = 1'b0;
    if (!held || !pressed_q) begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b1;
    end else if (rep_cnt_q == (rep_first_q ? REP_DELAY_LAST : REP_RATE_LAST)) begin
      rep_fire    = 1'b1;
      rep_cnt_d   = '0;
      rep_first_d = 1'b0;
    end else begin
      rep_cnt_d = rep_cnt_q + 1'b1;
    end
    press_d = press_d || rep_fire;
`endif
  end

  // Output registers; reset drops everything without emitting a pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pressed_q   <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
`endif
    end else begin
      pressed_q   <= pressed_d;
      press_q     <= press_d;
      release_q   <= release_d;
`ifdef KEY_REPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
`endif
    end
  end

  assign bus.pressed[0] = pressed_q;
  assign bus.press[0]   = press_q;
  assign bus.rel[0]     = release_q;

endmodule

// File: rtl/key_debouncer.sv
// Multi-key debouncer top: one independent key_debounce_ch per key, with the
// per-channel results packed into the output vectors.
// Optional feature macro: KEY_REPEAT_EN (auto-repeat press pulses while held).
module key_debouncer
  import pong_pkg::*;
#(
  parameter int N_KEYS              = 2,
  parameter int DEBOUNCE_CYCLES     = DEFAULT_DEBOUNCE_CYCLES,
  parameter int ACTIVE_LOW          = 1,
  parameter int REPEAT_DELAY_CYCLES = DEFAULT_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES  = DEFAULT_REPEAT_RATE_CYCLES
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N_KEYS-1:0] keys_i,
  output logic [N_KEYS-1:0] pressed_o,
  output logic [N_KEYS-1:0] press_o,
  output logic [N_KEYS-1:0] release_o
);

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_ch
    key_debouncer_if #(.W(1)) ch_if ();

    assign ch_if.keys[0] = keys_i[gi];
    assign pressed_o[gi] = ch_if.pressed[0];
    assign press_o[gi]   = ch_if.press[0];
    assign release_o[gi] = ch_if.rel[0];

    key_debounce_ch #(
      .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
      .ACTIVE_LOW          (ACTIVE_LOW),
      .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES)
    ) u_ch (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (ch_if)
    );
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer (N_KEYS=2, DEBOUNCE_CYCLES=4,
// ACTIVE_LOW=1, repeat 10/3). Honours KEY_REPEAT_EN when defined.
module tb_key_debouncer;

  localparam int N     = 2;
  localparam int DEB   = 4;
  localparam int AL    = 1;
  localparam int RDLY  = 10;
  localparam int RRATE = 3;
`ifdef KEY_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  key_debouncer_if #(.W(N)) tb_if ();

  key_debouncer #(
    .N_KEYS              (N),
    .DEBOUNCE_CYCLES     (DEB),
    .ACTIVE_LOW          (AL),
    .REPEAT_DELAY_CYCLES (RDLY),
    .REPEAT_RATE_CYCLES  (RRATE)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .keys_i    (tb_if.keys),
    .pressed_o (tb_if.pressed),
    .press_o   (tb_if.press),
    .release_o (tb_if.rel)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  // A key level is accepted once the synchronized sample has disagreed with
  // the current level for DEB+1 consecutive edges; outputs show it one edge later.
  int             cyc = 0;
  logic [N-1:0]   m_s1, m_s2, m_level, m_rose, m_fell;
  logic [N-1:0]   m_pressed, m_press, m_release;
  int             m_run [N];
  int             m_pt  [N];   // cycle of the last initial press pulse, -1 if none

  function automatic bit rep_due(input int e);
    return (e >= RDLY) && (((e - RDLY) % RRATE) == 0);
  endfunction

  function automatic void model_edge(input logic r, input logic [N-1:0] k);
    logic [N-1:0] kp;
    cyc++;
    kp = (AL != 0) ? ~k : k;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_rose = '0; m_fell = '0;
      m_pressed = '0; m_press = '0; m_release = '0;
      for (int i = 0; i < N; i++) begin
        m_run[i] = 0;
        m_pt[i]  = -1;
      end
      return;
    end
    for (int i = 0; i < N; i++) begin
      m_pressed[i] = m_level[i];
      m_release[i] = m_fell[i];
      m_press[i]   = m_rose[i] || (REP_ON && m_level[i] && (m_pt[i] >= 0) && rep_due(cyc - m_pt[i]));
      if (m_rose[i]) m_pt[i] = cyc;
      m_rose[i] = 1'b0;
      m_fell[i] = 1'b0;
      if (m_s2[i] != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB + 1) begin
          m_level[i] = m_s2[i];
          m_run[i]   = 0;
          if (m_level[i]) m_rose[i] = 1'b1;
          else begin
            m_fell[i] = 1'b1;
            m_pt[i]   = -1;
          end
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = kp;
  endfunction

  // One clock: model sees the same inputs as the DUT at the edge; return at negedge
  task automatic tick();
    @(posedge clk);
    model_edge(rst, tb_if.keys);
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tb_if.keys = N'($urandom_range(0, 3));
      tick();
      if ({tb_if.pressed, tb_if.press, tb_if.rel} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs cyc=%0d got pressed=%b press=%b release=%b want all 0",
                 cyc, tb_if.pressed, tb_if.press, tb_if.rel);
      end
      n_vec++;
      $display("reset  cyc=%0d keys=%b pressed=%b press=%b release=%b", cyc, tb_if.keys, tb_if.pressed, tb_if.press, tb_if.rel);
    end
    tb_if.keys = 2'b11;
    rst = 1'b0;
  endtask

  task automatic test_idle();
    int bad = 0;
    tb_if.keys = 2'b11;
    for (int k = 0; k < 100; k++) begin
      tick();
      if ({tb_if.pressed, tb_if.press, tb_if.rel} !== {m_pressed, m_press, m_release}) bad++;
      if ({tb_if.pressed, tb_if.press, tb_if.rel} !== '0) bad++;
    end
    if (bad !== 0) begin
      n_err++;
      $display("FAIL idle_quiet got %0d bad cycles want 0", bad);
    end
    n_vec++;
    $display("idle   100 cycles keys=11 bad_cycles=%0d", bad);
  endtask

  task automatic test_press_release();
    int lat_p = -1;
    int lat_r = -1;
    tb_if.keys[0] = 1'b0;
    for (int k = 1; k <= 28; k++) begin
      tick();
      if ({tb_if.pressed, tb_if.press, tb_if.rel} !== {m_pressed, m_press, m_release}) begin
        n_err++;
        $display("FAIL press_model cyc=%0d got %b/%b/%b want %b/%b/%b", cyc,
                 tb_if.pressed, tb_if.press, tb_if.rel, m_pressed, m_press, m_release);
      end
      n_vec++;
      if (lat_p < 0 && tb_if.press[0]) lat_p = k - 1;
    end
    if (lat_p !== DEB + 3) begin
      n_err++;
      $display("FAIL press_latency got %0d want %0d", lat_p, DEB + 3);
    end
    n_vec++;
    $display("press  key0 latency=%0d", lat_p);
    tb_if.keys[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if ({tb_if.pressed, tb_if.press, tb_if.rel} !== {m_pressed, m_press, m_release}) begin
        n_err++;
        $display("FAIL release_model cyc=%0d got %b/%b/%b want %b/%b/%b", cyc,
                 tb_if.pressed, tb_if.press, tb_if.rel, m_pressed, m_press, m_release);
      end
      n_vec++;
      if (lat_r < 0 && tb_if.rel[0]) lat_r = k - 1;
    end
    if (lat_r !== DEB + 3) begin
      n_err++;
      $display("FAIL release_latency got %0d want %0d", lat_r, DEB + 3);
    end
    n_vec++;
    $display("release key0 latency=%0d", lat_r);
  endtask

  task automatic test_glitch();
    int ev = 0;
    tb_if.keys[1] = 1'b0;
    for (int k = 0; k < 18; k++) begin
      if (k == 3) tb_if.keys[1] = 1'b1;
      tick();
      if ({tb_if.pressed, tb_if.press, tb_if.rel} !== {m_pressed, m_press, m_release}) begin
        n_err++;
        $display("FAIL glitch_model cyc=%0d got %b/%b/%b want %b/%b/%b", cyc,
                 tb_if.pressed, tb_if.press, tb_if.rel, m_pressed, m_press, m_release);
      end
      n_vec++;
      if (tb_if.pressed[1] || tb_if.press[1] || tb_if.rel[1]) ev++;
    end
    if (ev !== 0) begin
      n_err++;
      $display("FAIL glitch_reject got %0d active cycles on key1 want 0", ev);
    end
    n_vec++;
    $display("glitch key1 3-cycle low active_cycles=%0d", ev);
  endtask

  task automatic test_hold_reset();
    int lat = -1;
    int rel_seen = 0;
    logic [N-1:0] pv = '0;
    rst = 1'b1;
    tb_if.keys = 2'b10;
    for (int k = 0; k < 3; k++) tick();
    rst = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if ({tb_if.pressed, tb_if.press, tb_if.rel} !== {m_pressed, m_press, m_release}) begin
        n_err++;
        $display("FAIL hold_reset_model cyc=%0d got %b/%b/%b want %b/%b/%b", cyc,
                 tb_if.pressed, tb_if.press, tb_if.rel, m_pressed, m_press, m_release);
      end
      n_vec++;
      if (lat < 0 && tb_if.press !== '0) begin
        lat = k - 1;
        pv  = tb_if.press;
      end
      if (tb_if.rel !== '0) rel_seen++;
    end
    if (lat !== DEB + 3 || pv !== 2'b01 || rel_seen !== 0) begin
      n_err++;
      $display("FAIL hold_reset got latency=%0d press=%b releases=%0d want %0d 01 0", lat, pv, rel_seen, DEB + 3);
    end
    n_vec++;
    $display("hold_reset latency=%0d press=%b releases=%0d", lat, pv, rel_seen);
    tb_if.keys = 2'b11;
    for (int k = 0; k < 15; k++) begin
      tick();
      if ({tb_if.pressed, tb_if.press, tb_if.rel} !== {m_pressed, m_press, m_release}) begin
        n_err++;
        $display("FAIL hold_reset_release cyc=%0d got %b/%b/%b want %b/%b/%b", cyc,
                 tb_if.pressed, tb_if.press, tb_if.rel, m_pressed, m_press, m_release);
      end
      n_vec++;
    end
  endtask

  task automatic test_reset_abort();
    int lat = -1;
    int pulses = 0;
    logic [N-1:0] pv = '0;
    tb_if.keys = 2'b00;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (tb_if.press !== '0 || tb_if.rel !== '0) pulses++;
    end
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (tb_if.press !== '0 || tb_if.rel !== '0) pulses++;
    end
    rst = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if ({tb_if.pressed, tb_if.press, tb_if.rel} !== {m_pressed, m_press, m_release}) begin
        n_err++;
        $display("FAIL abort_model cyc=%0d got %b/%b/%b want %b/%b/%b", cyc,
                 tb_if.pressed, tb_if.press, tb_if.rel, m_pressed, m_press, m_release);
      end
      n_vec++;
      if (lat < 0 && tb_if.press !== '0) begin
        lat = k - 1;
        pv  = tb_if.press;
      end
    end
    if (pulses !== 0 || lat !== DEB + 3 || pv !== 2'b11) begin
      n_err++;
      $display("FAIL reset_abort got early_pulses=%0d latency=%0d press=%b want 0 %0d 11", pulses, lat, pv, DEB + 3);
    end
    n_vec++;
    $display("reset_abort early_pulses=%0d latency=%0d press=%b", pulses, lat, pv);
    tb_if.keys = 2'b11;
    for (int k = 0; k < 15; k++) tick();
  endtask

  task automatic test_repeat();
    int t0 = -1;
    int got [$];
    int want [$];
    tb_if.keys = 2'b10;
    for (int k = 1; k <= 20 && t0 < 0; k++) begin
      tick();
      if (tb_if.press[0]) t0 = k;
    end
    if (t0 >= 0) got.push_back(0);
    for (int j = 1; j <= 30; j++) begin
      tick();
      if ({tb_if.pressed, tb_if.press, tb_if.rel} !== {m_pressed, m_press, m_release}) begin
        n_err++;
        $display("FAIL repeat_model cyc=%0d got %b/%b/%b want %b/%b/%b", cyc,
                 tb_if.pressed, tb_if.press, tb_if.rel, m_pressed, m_press, m_release);
      end
      n_vec++;
      if (tb_if.press[0]) got.push_back(j);
    end
    want.push_back(0);
    if (REP_ON) begin
      for (int o = RDLY; o <= 30; o += RRATE) want.push_back(o);
    end
    if (got.size() !== want.size()) begin
      n_err++;
      $display("FAIL repeat_count got %0d pulses want %0d", got.size(), want.size());
    end else begin
      for (int i = 0; i < want.size(); i++) begin
        if (got[i] !== want[i]) begin
          n_err++;
          $display("FAIL repeat_offset idx=%0d got +%0d want +%0d", i, got[i], want[i]);
        end
      end
    end
    n_vec++;
    $display("repeat key0 pulses=%0d expected=%0d", got.size(), want.size());
    tb_if.keys = 2'b11;
    for (int k = 0; k < 15; k++) begin
      tick();
      if ({tb_if.pressed, tb_if.press, tb_if.rel} !== {m_pressed, m_press, m_release}) begin
        n_err++;
        $display("FAIL repeat_release cyc=%0d got %b/%b/%b want %b/%b/%b", cyc,
                 tb_if.pressed, tb_if.press, tb_if.rel, m_pressed, m_press, m_release);
      end
      n_vec++;
    end
  endtask

  task automatic test_random();
    int remain [N];
    for (int i = 0; i < N; i++) remain[i] = 1;
    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < N; i++) begin
        remain[i]--;
        if (remain[i] <= 0) begin
          tb_if.keys[i] = ~tb_if.keys[i];
          remain[i] = $urandom_range(1, 10);
        end
      end
      rst = ($urandom_range(0, 99) == 0);
      tick();
      if ({tb_if.pressed, tb_if.press, tb_if.rel} !== {m_pressed, m_press, m_release}) begin
        n_err++;
        $display("FAIL random_model cyc=%0d got %b/%b/%b want %b/%b/%b", cyc,
                 tb_if.pressed, tb_if.press, tb_if.rel, m_pressed, m_press, m_release);
      end
      n_vec++;
      if ((tb_if.press & tb_if.rel) !== '0) begin
        n_err++;
        $display("FAIL press_release_overlap cyc=%0d got %b want 00", cyc, tb_if.press & tb_if.rel);
      end
      n_vec++;
      if (tb_if.press !== '0 || tb_if.rel !== '0)
        $display("random cyc=%0d rst=%b keys=%b pressed=%b press=%b release=%b",
                 cyc, rst, tb_if.keys, tb_if.pressed, tb_if.press, tb_if.rel);
    end
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    tb_if.keys = 2'b11;
    test_reset();
    test_idle();
    test_press_release();
    test_glitch();
    test_hold_reset();
    test_reset_abort();
    test_repeat();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
